// File: rtl/trdb_pkg.sv
// Shared definitions for the trace-encoder register bank: register offsets,
// activation FSM states and the packed mode-bit layout.
package trdb_pkg;

   localparam int unsigned CTRL_OFF        = 'h00;
   localparam int unsigned MODE_OFF        = 'h04;
   localparam int unsigned RESYNC_OFF      = 'h08;
   localparam int unsigned STATUS_OFF      = 'h0C;
   localparam int unsigned FILTER_BASE_OFF = 'h10;

   localparam int unsigned MODE_W = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_DRAIN  = 2'd3
   } trdb_reg_state_e;

   // First member is the MSB, so nocontext lands on bit 0.
   typedef struct packed {
      logic jump_target_cache;
      logic branch_prediction;
      logic implicit_return;
      logic sijump;
      logic implicit_exception;
      logic full_address;
      logic delta_address;
      logic encoder_mode;
      logic notime;
      logic nocontext;
   } trdb_mode_t;

   function automatic int unsigned filter_en_off(input int unsigned num_filters);
      return FILTER_BASE_OFF + 8 * num_filters;
   endfunction

endpackage

// File: rtl/trdb_reg_filter_ch.sv
// One address-range filter channel: LO/HI staging registers, bus decode,
// and active copies that follow staging while commit_i is high.
module trdb_reg_filter_ch #(
   parameter int          XLEN    = 32,
   parameter int          PADDR_W = 12,
   parameter int unsigned LO_OFF  = 'h10
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               wr_i,
   input  logic [PADDR_W-1:0] addr_i,
   input  logic [XLEN-1:0]    wdata_i,
   input  logic               commit_i,
   output logic [XLEN-1:0]    lo_o,
   output logic [XLEN-1:0]    hi_o,
   output logic [XLEN-1:0]    rdata_o,
   output logic               hit_o
);

   logic [XLEN-1:0] lo_stg;
   logic [XLEN-1:0] hi_stg;
   logic            sel_lo;
   logic            sel_hi;

   assign sel_lo = (addr_i == PADDR_W'(LO_OFF));
   assign sel_hi = (addr_i == PADDR_W'(LO_OFF + 4));
   assign hit_o  = sel_lo | sel_hi;

   always_comb begin
      rdata_o = '0;
      if (sel_lo)
         rdata_o = lo_stg;
      else if (sel_hi)
         rdata_o = hi_stg;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lo_stg <= '0;
         hi_stg <= '0;
         lo_o   <= '0;
         hi_o   <= '0;
      end else begin
         if (wr_i && sel_lo)
            lo_stg <= wdata_i;
         if (wr_i && sel_hi)
            hi_stg <= wdata_i;
         if (commit_i) begin
            lo_o <= lo_stg;
            hi_o <= hi_stg;
         end
      end
   end

endmodule

// File: rtl/trdb_reg_bank.sv
// APB control/status register bank for the trace encoder: staged config with
// frozen active copies, trace activation FSM, sticky overflow and flush pulse.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | not tracing; staging is copied to outputs every cycle
//   ST_ARMED  | enable seen, config frozen; one cycle before tracing
//   ST_ACTIVE | trace_activated_o high, encoder may emit packets
//   ST_DRAIN  | enable dropped; waiting for encoder_idle_i
import trdb_pkg::*;

module trdb_reg_bank #(
   parameter int XLEN        = 32,
   parameter int PADDR_W     = 12,
   parameter int NUM_FILTERS = 2,
   parameter int RESYNC_W    = 16
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                psel_i,
   input  logic                                penable_i,
   input  logic                                pwrite_i,
   input  logic [PADDR_W-1:0]                  paddr_i,
   input  logic [XLEN-1:0]                     pwdata_i,
   output logic [XLEN-1:0]                     prdata_o,
   output logic                                pready_o,
   output logic                                pslverr_o,
   input  logic                                encoder_idle_i,
   input  logic                                overflow_i,
   output logic                                trace_activated_o,
   output logic                                busy_o,
   output logic                                flush_o,
   output logic                                nocontext_o,
   output logic                                notime_o,
   output logic                                encoder_mode_o,
   output logic                                delta_address_o,
   output logic                                full_address_o,
   output logic                                implicit_exception_o,
   output logic                                sijump_o,
   output logic                                implicit_return_o,
   output logic                                branch_prediction_o,
   output logic                                jump_target_cache_o,
   output logic [RESYNC_W-1:0]                 resync_max_o,
   output logic [NUM_FILTERS-1:0][XLEN-1:0]    filter_lo_o,
   output logic [NUM_FILTERS-1:0][XLEN-1:0]    filter_hi_o,
   output logic [NUM_FILTERS-1:0]              filter_en_o
);

   trdb_reg_state_e         state, state_nxt;
   logic                    enable;
   logic                    overflow;
   logic                    flush_q;
   trdb_mode_t              mode_stg, mode_act;
   logic [RESYNC_W-1:0]     resync_stg;
   logic [NUM_FILTERS-1:0]  en_stg;
   logic [PADDR_W-1:0]      addr;
   logic                    access, wr, commit, mapped;
   logic                    sel_ctrl, sel_mode, sel_resync, sel_status, sel_en;
   logic [XLEN-1:0]         rdata;
   logic [XLEN-1:0]         ch_rdata [NUM_FILTERS];
   logic [NUM_FILTERS-1:0]  ch_hit;
   logic                    unused_addr_lsb;

   assign unused_addr_lsb = ^paddr_i[1:0];

   assign addr       = {paddr_i[PADDR_W-1:2], 2'b00};
   assign access     = psel_i & penable_i;
   assign wr         = access & pwrite_i;
   assign commit     = (state == ST_IDLE);
   assign sel_ctrl   = (addr == PADDR_W'(CTRL_OFF));
   assign sel_mode   = (addr == PADDR_W'(MODE_OFF));
   assign sel_resync = (addr == PADDR_W'(RESYNC_OFF));
   assign sel_status = (addr == PADDR_W'(STATUS_OFF));
   assign sel_en     = (addr == PADDR_W'(filter_en_off(NUM_FILTERS)));
   assign mapped     = sel_ctrl | sel_mode | sel_resync | sel_status | sel_en | (|ch_hit);

   assign pready_o  = 1'b1;
   assign pslverr_o = access & ~mapped & ~rst_i;
   assign prdata_o  = rdata;

   always_comb begin
      rdata = '0;
      if (sel_ctrl) begin
         rdata[0] = enable;
         rdata[1] = (state == ST_ACTIVE);
      end else if (sel_mode)
         rdata[MODE_W-1:0] = mode_stg;
      else if (sel_resync)
         rdata[RESYNC_W-1:0] = resync_stg;
      else if (sel_status)
         rdata[1:0] = {state != ST_IDLE, overflow};
      else if (sel_en)
         rdata[NUM_FILTERS-1:0] = en_stg;
      else
         for (int i = 0; i < NUM_FILTERS; i++)
            rdata = rdata | ch_rdata[i];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (enable) state_nxt = ST_ARMED;
         ST_ARMED:  state_nxt = enable ? ST_ACTIVE : ST_IDLE;
         ST_ACTIVE: if (!enable) state_nxt = ST_DRAIN;
         ST_DRAIN:  if (encoder_idle_i) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= ST_IDLE;
         enable       <= 1'b0;
         overflow     <= 1'b0;
         flush_q      <= 1'b0;
         mode_stg     <= '0;
         mode_act     <= '0;
         resync_stg   <= '1;
         resync_max_o <= '1;
         en_stg       <= '0;
         filter_en_o  <= '0;
      end else begin
         state   <= state_nxt;
         flush_q <= wr & sel_ctrl & pwdata_i[2];
         if (wr && sel_ctrl)
            enable <= pwdata_i[0];
         if (wr && sel_mode)
            mode_stg <= trdb_mode_t'(pwdata_i[MODE_W-1:0]);
         if (wr && sel_resync)
            resync_stg <= pwdata_i[RESYNC_W-1:0];
         if (wr && sel_en)
            en_stg <= pwdata_i[NUM_FILTERS-1:0];
         // A new overflow in the same cycle as the clear must not be lost.
         if (overflow_i)
            overflow <= 1'b1;
         else if (wr && sel_status && pwdata_i[0])
            overflow <= 1'b0;
         if (commit) begin
            mode_act     <= mode_stg;
            resync_max_o <= resync_stg;
            filter_en_o  <= en_stg;
         end
      end
   end

   for (genvar i = 0; i < NUM_FILTERS; i++) begin : g_filter
      trdb_reg_filter_ch #(
         .XLEN    (XLEN),
         .PADDR_W (PADDR_W),
         .LO_OFF  (FILTER_BASE_OFF + 8 * i)
      ) u_ch (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .wr_i     (wr),
         .addr_i   (addr),
         .wdata_i  (pwdata_i),
         .commit_i (commit),
         .lo_o     (filter_lo_o[i]),
         .hi_o     (filter_hi_o[i]),
         .rdata_o  (ch_rdata[i]),
         .hit_o    (ch_hit[i])
      );
   end

   assign trace_activated_o    = (state == ST_ACTIVE);
   assign busy_o               = (state != ST_IDLE);
   assign flush_o              = flush_q;
   assign nocontext_o          = mode_act.nocontext;
   assign notime_o             = mode_act.notime;
   assign encoder_mode_o       = mode_act.encoder_mode;
   assign delta_address_o      = mode_act.delta_address;
   assign full_address_o       = mode_act.full_address;
   assign implicit_exception_o = mode_act.implicit_exception;
   assign sijump_o             = mode_act.sijump;
   assign implicit_return_o    = mode_act.implicit_return;
   assign branch_prediction_o  = mode_act.branch_prediction;
   assign jump_target_cache_o  = mode_act.jump_target_cache;

endmodule

// File: tb/tb_trdb_reg_bank.sv
// Directed bench for trdb_reg_bank: APB reads/writes with hand-computed
// expectations for staging/commit timing, FSM, overflow, filters and flush.
module tb_trdb_reg_bank;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic             psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
   logic [11:0]      paddr_i = '0;
   logic [31:0]      pwdata_i = '0;
   logic [31:0]      prdata_o;
   logic             pready_o, pslverr_o;
   logic             encoder_idle_i = 1'b1;
   logic             overflow_i = 1'b0;
   logic             trace_activated_o, busy_o, flush_o;
   logic             nocontext_o, notime_o, encoder_mode_o, delta_address_o, full_address_o;
   logic             implicit_exception_o, sijump_o, implicit_return_o;
   logic             branch_prediction_o, jump_target_cache_o;
   logic [15:0]      resync_max_o;
   logic [1:0][31:0] filter_lo_o, filter_hi_o;
   logic [1:0]       filter_en_o;
   logic [9:0]       mode_v;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   trdb_reg_bank #(.XLEN(32), .PADDR_W(12), .NUM_FILTERS(2), .RESYNC_W(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
      .paddr_i(paddr_i), .pwdata_i(pwdata_i), .prdata_o(prdata_o),
      .pready_o(pready_o), .pslverr_o(pslverr_o),
      .encoder_idle_i(encoder_idle_i), .overflow_i(overflow_i),
      .trace_activated_o(trace_activated_o), .busy_o(busy_o), .flush_o(flush_o),
      .nocontext_o(nocontext_o), .notime_o(notime_o), .encoder_mode_o(encoder_mode_o),
      .delta_address_o(delta_address_o), .full_address_o(full_address_o),
      .implicit_exception_o(implicit_exception_o), .sijump_o(sijump_o),
      .implicit_return_o(implicit_return_o), .branch_prediction_o(branch_prediction_o),
      .jump_target_cache_o(jump_target_cache_o), .resync_max_o(resync_max_o),
      .filter_lo_o(filter_lo_o), .filter_hi_o(filter_hi_o), .filter_en_o(filter_en_o)
   );

   assign mode_v = {jump_target_cache_o, branch_prediction_o, implicit_return_o, sijump_o,
                    implicit_exception_o, full_address_o, delta_address_o, encoder_mode_o,
                    notime_o, nocontext_o};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Returns at the falling edge after the access edge.
   task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk_i);
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = a; pwdata_i = d;
      @(negedge clk_i);
      penable_i = 1'b1;
      @(negedge clk_i);
      psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
   endtask

   task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
      @(negedge clk_i);
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = a;
      @(negedge clk_i);
      penable_i = 1'b1;
      #1;
      d = prdata_o;
      e = pslverr_o;
      @(negedge clk_i);
      psel_i = 1'b0; penable_i = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic        e;
      apb_read(a, d, e);
      chk(tag, {31'd0, e, d}, {31'd0, 1'b0, exp});
   endtask

   initial begin
      logic [31:0] d;
      logic        e;
      logic [11:0] rd_addr [9];
      logic [31:0] rd_exp  [9];
      rd_addr = '{12'h00, 12'h04, 12'h08, 12'h0C, 12'h10, 12'h14, 12'h18, 12'h1C, 12'h20};
      rd_exp  = '{32'h0, 32'h0, 32'hFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Reset values
      chk("rst_pready", pready_o, 1);
      chk("rst_busy", busy_o, 0);
      chk("rst_act", trace_activated_o, 0);
      chk("rst_flush", flush_o, 0);
      chk("rst_resync_out", resync_max_o, 16'hFFFF);
      chk("rst_mode_out", mode_v, 0);
      for (int i = 0; i < 9; i++)
         rd_chk($sformatf("rst_read_%0h", rd_addr[i]), rd_addr[i], rd_exp[i]);

      // Staged write in IDLE: staging at access edge, outputs one edge later
      apb_write(12'h04, 32'h3FF);
      chk("mode_not_yet", mode_v, 0);
      @(negedge clk_i);
      chk("mode_committed", mode_v, 10'h3FF);

      // Activation
      apb_write(12'h00, 32'h1);
      chk("en_busy_t0", busy_o, 0);
      @(negedge clk_i);
      chk("en_busy_t1", busy_o, 1);
      chk("en_act_t1", trace_activated_o, 0);
      @(negedge clk_i);
      chk("en_act_t2", trace_activated_o, 1);
      rd_chk("ctrl_active", 12'h00, 32'h3);

      // Frozen while active
      apb_write(12'h04, 32'h0);
      @(negedge clk_i);
      chk("mode_frozen", mode_v, 10'h3FF);
      rd_chk("mode_stg_read", 12'h04, 32'h0);

      // Drain holds until encoder idle
      encoder_idle_i = 1'b0;
      apb_write(12'h00, 32'h0);
      @(negedge clk_i);
      chk("drain_act", trace_activated_o, 0);
      repeat (5) @(negedge clk_i);
      chk("drain_busy", busy_o, 1);
      rd_chk("drain_status", 12'h0C, 32'h2);
      encoder_idle_i = 1'b1;
      @(negedge clk_i);
      chk("idle_busy", busy_o, 0);
      chk("idle_mode_hold", mode_v, 10'h3FF);
      @(negedge clk_i);
      chk("idle_mode_commit", mode_v, 10'h0);

      // Sticky overflow, set wins over clear
      overflow_i = 1'b1;
      @(negedge clk_i);
      overflow_i = 1'b0;
      rd_chk("ovf_set", 12'h0C, 32'h1);
      overflow_i = 1'b1;
      apb_write(12'h0C, 32'h1);
      overflow_i = 1'b0;
      rd_chk("ovf_set_wins", 12'h0C, 32'h1);
      apb_write(12'h0C, 32'h1);
      rd_chk("ovf_cleared", 12'h0C, 32'h0);

      // ARMED with enable dropped goes back to IDLE
      @(negedge clk_i);
      psel_i = 1'b1; penable_i = 1'b1; pwrite_i = 1'b1; paddr_i = 12'h00; pwdata_i = 32'h1;
      @(negedge clk_i);
      pwdata_i = 32'h0;
      @(negedge clk_i);
      psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
      chk("armed_busy", busy_o, 1);
      chk("armed_act", trace_activated_o, 0);
      @(negedge clk_i);
      chk("armed_abort_busy", busy_o, 0);
      chk("armed_abort_act", trace_activated_o, 0);

      // Filters
      apb_write(12'h10, 32'h0000_1234);
      apb_write(12'h1C, 32'h8000_1000);
      chk("fhi_not_yet", filter_hi_o[1], 0);
      @(negedge clk_i);
      chk("fhi_commit", filter_hi_o[1], 32'h8000_1000);
      chk("flo0_commit", filter_lo_o[0], 32'h0000_1234);
      apb_write(12'h20, 32'h2);
      chk("fen_not_yet", filter_en_o, 0);
      @(negedge clk_i);
      chk("fen_commit", filter_en_o, 2'b10);
      rd_chk("fhi_read", 12'h1C, 32'h8000_1000);
      rd_chk("fen_read", 12'h20, 32'h2);
      apb_write(12'h24, 32'hFFFF_FFFF);
      apb_read(12'h24, d, e);
      chk("unmapped_err", e, 1);
      chk("unmapped_data", d, 0);

      // Flush while ACTIVE, resync staged but frozen
      apb_write(12'h00, 32'h1);
      repeat (2) @(negedge clk_i);
      chk("flush_pre_act", trace_activated_o, 1);
      apb_write(12'h08, 32'h0010);
      apb_write(12'h00, 32'h5);
      chk("flush_pulse", flush_o, 1);
      @(negedge clk_i);
      chk("flush_single", flush_o, 0);
      chk("flush_act_kept", trace_activated_o, 1);
      chk("resync_frozen", resync_max_o, 16'hFFFF);
      rd_chk("ctrl_after_flush", 12'h00, 32'h3);
      apb_write(12'h00, 32'h0);
      @(negedge clk_i);
      chk("stop_drain_busy", busy_o, 1);
      @(negedge clk_i);
      chk("stop_idle_busy", busy_o, 0);
      chk("resync_hold", resync_max_o, 16'hFFFF);
      @(negedge clk_i);
      chk("resync_commit", resync_max_o, 16'h0010);

      // Reset in DRAIN aborts immediately
      encoder_idle_i = 1'b0;
      apb_write(12'h00, 32'h1);
      repeat (2) @(negedge clk_i);
      apb_write(12'h00, 32'h0);
      @(negedge clk_i);
      chk("pre_rst_drain", busy_o, 1);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      chk("midrst_busy", busy_o, 0);
      chk("midrst_resync", resync_max_o, 16'hFFFF);
      chk("midrst_fen", filter_en_o, 0);
      chk("midrst_fhi", filter_hi_o[1], 0);
      rd_chk("midrst_ctrl", 12'h00, 32'h0);
      rd_chk("midrst_resync_rd", 12'h08, 32'hFFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
